// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: FSM states, trap codes,
// load/store width codes and RV32I major opcodes.
package core_sequencer_pkg;

    localparam int unsigned BE_WIDTH    = 4;
    localparam int unsigned TRAP_WIDTH  = 2;
    localparam int unsigned F3_WIDTH    = 3;
    localparam int unsigned OPC_WIDTH   = 7;

    // Sequencer states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Trap cause codes reported while halted
    localparam logic [TRAP_WIDTH-1:0] TRAP_NONE     = 2'd0;
    localparam logic [TRAP_WIDTH-1:0] TRAP_ILLEGAL  = 2'd1;
    localparam logic [TRAP_WIDTH-1:0] TRAP_MISALIGN = 2'd2;
    localparam logic [TRAP_WIDTH-1:0] TRAP_TIMEOUT  = 2'd3;

    // funct3 access-width codes for loads/stores
    localparam logic [F3_WIDTH-1:0] F3_SB = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_SH = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_SW = 3'b010;

    // RV32I major opcodes, matching the decoder flag inputs
    localparam logic [OPC_WIDTH-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_WIDTH-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_WIDTH-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_WIDTH-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_WIDTH-1:0] OPC_IMM    = 7'b0010011;
    localparam logic [OPC_WIDTH-1:0] OPC_ALU    = 7'b0110011;
    localparam logic [OPC_WIDTH-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_WIDTH-1:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/store_mask_gen.sv
// Store byte-enable and alignment check for the core sequencer.
// Optional feature macro: MISALIGN_TRAP_EN (enables the misalignment flag;
// without it the flag is tied low and no alignment check is made).
module store_mask_gen
    import core_sequencer_pkg::*;
(
    input  logic [F3_WIDTH-1:0] funct3,
    input  logic [1:0]          addr_lo,
    output logic [BE_WIDTH-1:0] mask,
    output logic                misaligned
);

    // Byte enables by access width; shifted halfwords truncate at the word edge
    always_comb begin
        mask = '0;
        case (funct3)
            F3_SB:   mask = 4'b0001 << addr_lo;
            F3_SH:   mask = 4'b0011 << addr_lo;
            F3_SW:   mask = 4'b1111;
            default: mask = '0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Halfword needs even address, word needs word-aligned address (unsigned loads included)
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with trap-to-HALT.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned load/store traps in EXEC).
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_LUI,
    input  logic                  is_AUIPC,
    input  logic                  is_JAL,
    input  logic                  is_JALR,
    input  logic                  is_BRANCH,
    input  logic                  is_LOAD,
    input  logic                  is_STORE,
    input  logic                  is_IMM,
    input  logic                  is_ALU,
    input  logic                  is_FENCE,
    input  logic                  is_SYSTEM,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic                  branch_taken,
    input  logic                  imem_ack,
    input  logic                  dmem_ack,
    output logic                  imem_req,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  pc_sel,
    output logic                  rf_we,
    output logic                  dmem_req,
    output logic [3:0]            dmem_we,
    output logic                  halt,
    output logic [1:0]            trap_cause,
    output logic [CNT_WIDTH-1:0]  instret
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_expired;
    logic                wait_active;
    logic [1:0]          trap_next;

    logic                any_op;
    logic                is_mem_op;
    logic [3:0]          store_mask;
    logic                misaligned;

    logic                imem_req_s;
    logic                ir_we_s;
    logic                pc_we_s;
    logic                pc_sel_s;
    logic                rf_we_s;
    logic                dmem_req_s;
    logic [3:0]          dmem_we_s;

    assign any_op    = is_LUI | is_AUIPC | is_JAL | is_JALR | is_BRANCH | is_LOAD |
                       is_STORE | is_IMM | is_ALU | is_FENCE | is_SYSTEM;
    assign is_mem_op = is_LOAD | is_STORE;

    // The last allowed wait cycle is when the counter reads MEM_TIMEOUT-1
    assign wait_active  = (state == FETCH) || (state == MEM);
    assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    store_mask_gen u_store_mask_gen (
        .funct3     (funct3),
        .addr_lo    (addr_lo),
        .mask       (store_mask),
        .misaligned (misaligned)
    );

    // State, trap cause and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            trap_cause <= TRAP_NONE;
            instret    <= '0;
        end else begin
            state      <= state_next;
            trap_cause <= trap_next;
            if (pc_we_s) begin
                instret <= instret + CNT_WIDTH'(1);
            end
        end
    end

    // Wait counter restarts on every state change, counts while waiting for an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (wait_active) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Next-state and strobe decode of the registered state; acks beat the timeout
    always_comb begin
        state_next = state;
        trap_next  = trap_cause;
        imem_req_s = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        pc_sel_s   = 1'b0;
        rf_we_s    = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = '0;

        case (state)
            FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ack) begin
                    ir_we_s    = 1'b1;
                    state_next = DECODE;
                end else if (wait_expired) begin
                    state_next = HALT;
                    trap_next  = TRAP_TIMEOUT;
                end
            end

            DECODE: begin
                if (!any_op) begin
                    state_next = HALT;
                    trap_next  = TRAP_ILLEGAL;
                end else if (is_SYSTEM) begin
                    state_next = HALT;
                    trap_next  = TRAP_NONE;
                end else begin
                    state_next = EXEC;
                end
            end

            EXEC: begin
                if (is_mem_op) begin
                    if (misaligned) begin
                        state_next = HALT;
                        trap_next  = TRAP_MISALIGN;
                    end else begin
                        state_next = MEM;
                    end
                end else if (is_BRANCH) begin
                    pc_we_s    = 1'b1;
                    pc_sel_s   = branch_taken;
                    state_next = FETCH;
                end else if (is_FENCE) begin
                    pc_we_s    = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end

            MEM: begin
                dmem_req_s = 1'b1;
                if (is_STORE) begin
                    dmem_we_s = store_mask;
                end
                if (dmem_ack) begin
                    if (is_LOAD) begin
                        state_next = WB;
                    end else begin
                        pc_we_s    = 1'b1;
                        state_next = FETCH;
                    end
                end else if (wait_expired) begin
                    state_next = HALT;
                    trap_next  = TRAP_TIMEOUT;
                end
            end

            WB: begin
                rf_we_s    = 1'b1;
                pc_we_s    = 1'b1;
                pc_sel_s   = is_JAL | is_JALR;
                state_next = FETCH;
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = HALT;
            end
        endcase
    end

    // Strobes are forced low while reset is held, independent of the clock
    assign imem_req = rst_n & imem_req_s;
    assign ir_we    = rst_n & ir_we_s;
    assign pc_we    = rst_n & pc_we_s;
    assign pc_sel   = rst_n & pc_sel_s;
    assign rf_we    = rst_n & rf_we_s;
    assign dmem_req = rst_n & dmem_req_s;
    assign dmem_we  = {BE_WIDTH{rst_n}} & dmem_we_s;
    assign halt     = (state == HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_core_sequencer;

    localparam int CW    = 4;
    localparam int NEVER = 99;

    typedef enum int {
        OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
        OP_STORE, OP_IMM, OP_ALU, OP_FENCE, OP_SYSTEM
    } op_e;

    typedef struct {
        op_e        op;
        logic [2:0] f3;
        logic [1:0] addr;
        logic       bt;
        int         fw;      // fetch cycles without ack before ack
        int         mw;      // mem cycles without ack before ack
        int         cycles;  // expected cycles until retire or halt visible
        int         ir_cyc;  // expected cycle of ir_we (0 = never)
        logic       rf;
        logic       sel;
        logic [3:0] we;
        logic       dreq;
        logic       hlt;
        logic [1:0] trap;
    } vec_t;

    logic clk, rst_n;
    logic is_LUI, is_AUIPC, is_JAL, is_JALR, is_BRANCH, is_LOAD, is_STORE;
    logic is_IMM, is_ALU, is_FENCE, is_SYSTEM;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic branch_taken, imem_ack, dmem_ack;
    logic imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, halt;
    logic [3:0] dmem_we;
    logic [1:0] trap_cause;
    logic [CW-1:0] instret;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_instret = 0;
    vec_t vecs[$];
    vec_t sb[$];

    core_sequencer #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .is_LUI(is_LUI), .is_AUIPC(is_AUIPC), .is_JAL(is_JAL), .is_JALR(is_JALR),
        .is_BRANCH(is_BRANCH), .is_LOAD(is_LOAD), .is_STORE(is_STORE), .is_IMM(is_IMM),
        .is_ALU(is_ALU), .is_FENCE(is_FENCE), .is_SYSTEM(is_SYSTEM),
        .funct3(funct3), .addr_lo(addr_lo), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .halt(halt),
        .trap_cause(trap_cause), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input op_e op, input logic [2:0] f3, input logic [1:0] addr,
                                input logic bt, input int fw, input int mw, input int cycles,
                                input logic rf, input logic sel, input logic [3:0] we,
                                input logic dreq, input logic hlt, input logic [1:0] trap);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.bt = bt; v.fw = fw; v.mw = mw;
        v.cycles = cycles; v.rf = rf; v.sel = sel; v.we = we; v.dreq = dreq;
        v.hlt = hlt; v.trap = trap;
        v.ir_cyc = (fw < 4) ? fw + 1 : 0;
        return v;
    endfunction

    task automatic set_op(input op_e op);
        {is_LUI, is_AUIPC, is_JAL, is_JALR, is_BRANCH, is_LOAD, is_STORE,
         is_IMM, is_ALU, is_FENCE, is_SYSTEM} = '0;
        case (op)
            OP_LUI:    is_LUI = 1'b1;
            OP_AUIPC:  is_AUIPC = 1'b1;
            OP_JAL:    is_JAL = 1'b1;
            OP_JALR:   is_JALR = 1'b1;
            OP_BRANCH: is_BRANCH = 1'b1;
            OP_LOAD:   is_LOAD = 1'b1;
            OP_STORE:  is_STORE = 1'b1;
            OP_IMM:    is_IMM = 1'b1;
            OP_ALU:    is_ALU = 1'b1;
            OP_FENCE:  is_FENCE = 1'b1;
            OP_SYSTEM: is_SYSTEM = 1'b1;
            default: ;
        endcase
    endtask

    // Release reset just after a rising edge so the first FETCH cycle starts with a clean wait count
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_instret = 0;
    endtask

    task automatic run_one(input int idx, input vec_t v);
        int cyc = 0, fcnt = 0, mcnt = 0, ir_cyc = 0, we_bad = 0, strobe_at_halt = 0;
        bit done = 0, rf_seen = 0, dreq_seen = 0;
        logic sel_seen = 1'b0;
        logic [3:0] we_or = '0;
        vec_t e;
        set_op(v.op);
        funct3 = v.f3; addr_lo = v.addr; branch_taken = v.bt;
        sb.push_back(v);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            imem_ack = imem_req && (fcnt == v.fw);
            dmem_ack = dmem_req && (mcnt == v.mw);
            if (imem_req) fcnt++;
            if (dmem_req) mcnt++;
            #1;
            if (ir_we) ir_cyc = cyc;
            if (rf_we) rf_seen = 1;
            if (dmem_req) dreq_seen = 1;
            we_or |= dmem_we;
            if ((dmem_we != 4'b0000 && !dmem_req) || (dmem_req && dmem_we !== v.we)) we_bad++;
            if (pc_we) begin
                sel_seen = pc_sel;
                done = 1;
            end
            if (halt) begin
                done = 1;
                strobe_at_halt = int'({imem_req, ir_we, pc_we, rf_we, dmem_req, |dmem_we});
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL v%0d bound: got no retire/halt expected completion within 40 cycles", idx);
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        e = sb.pop_front();
        if (!e.hlt) exp_instret = (exp_instret + 1) % 16;
        check($sformatf("v%0d cycles", idx), cyc, e.cycles);
        check($sformatf("v%0d ir_we_cycle", idx), ir_cyc, e.ir_cyc);
        check($sformatf("v%0d rf_we", idx), rf_seen, e.rf);
        check($sformatf("v%0d dmem_req", idx), dreq_seen, e.dreq);
        check($sformatf("v%0d dmem_we", idx), we_or, e.we);
        check($sformatf("v%0d dmem_we_hold", idx), we_bad, 0);
        check($sformatf("v%0d halt", idx), halt, e.hlt);
        check($sformatf("v%0d trap_cause", idx), trap_cause, e.trap);
        check($sformatf("v%0d instret", idx), instret, exp_instret);
        if (!e.hlt) begin
            check($sformatf("v%0d pc_sel", idx), sel_seen, e.sel);
        end else begin
            check($sformatf("v%0d halt_strobes", idx), strobe_at_halt, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                imem_ack = 1'b1; dmem_ack = 1'b1;
                #1;
                check($sformatf("v%0d absorb_halt", idx), halt, 1);
                check($sformatf("v%0d absorb_strobes", idx),
                      {imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we}, 0);
            end
            apply_reset();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        funct3 = 3'b000; addr_lo = 2'b00;
        set_op(OP_NONE);

        //        op         f3      addr   bt fw     mw     cyc rf sel we       dreq hlt trap
        vecs.push_back(mk(OP_ALU,    3'b000, 2'b00, 0, 2,     0,     6, 1, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_IMM,    3'b000, 2'b00, 0, 0,     0,     4, 1, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_LUI,    3'b000, 2'b00, 0, 1,     0,     5, 1, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_AUIPC,  3'b000, 2'b00, 0, 0,     0,     4, 1, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_JAL,    3'b000, 2'b00, 0, 0,     0,     4, 1, 1, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_JALR,   3'b000, 2'b00, 0, 3,     0,     7, 1, 1, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_BRANCH, 3'b000, 2'b00, 1, 0,     0,     3, 0, 1, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_BRANCH, 3'b001, 2'b00, 0, 0,     0,     3, 0, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_FENCE,  3'b000, 2'b00, 0, 0,     0,     3, 0, 0, 4'b0000, 0, 0, 2'd0));
        vecs.push_back(mk(OP_LOAD,   3'b010, 2'b00, 0, 0,     0,     5, 1, 0, 4'b0000, 1, 0, 2'd0));
        vecs.push_back(mk(OP_LOAD,   3'b000, 2'b11, 0, 0,     2,     7, 1, 0, 4'b0000, 1, 0, 2'd0));
        vecs.push_back(mk(OP_STORE,  3'b001, 2'b10, 0, 0,     1,     5, 0, 0, 4'b1100, 1, 0, 2'd0));
        vecs.push_back(mk(OP_STORE,  3'b000, 2'b11, 0, 0,     0,     4, 0, 0, 4'b1000, 1, 0, 2'd0));
        vecs.push_back(mk(OP_STORE,  3'b010, 2'b00, 0, 0,     3,     7, 0, 0, 4'b1111, 1, 0, 2'd0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(OP_LOAD,   3'b001, 2'b01, 0, 0,     0,     4, 0, 0, 4'b0000, 0, 1, 2'd2));
        vecs.push_back(mk(OP_STORE,  3'b001, 2'b11, 0, 0,     0,     4, 0, 0, 4'b0000, 0, 1, 2'd2));
        vecs.push_back(mk(OP_LOAD,   3'b010, 2'b01, 0, 0,     0,     4, 0, 0, 4'b0000, 0, 1, 2'd2));
`else
        vecs.push_back(mk(OP_LOAD,   3'b001, 2'b01, 0, 0,     0,     5, 1, 0, 4'b0000, 1, 0, 2'd0));
        vecs.push_back(mk(OP_STORE,  3'b001, 2'b11, 0, 0,     0,     4, 0, 0, 4'b1000, 1, 0, 2'd0));
        vecs.push_back(mk(OP_LOAD,   3'b010, 2'b01, 0, 0,     0,     5, 1, 0, 4'b0000, 1, 0, 2'd0));
`endif
        vecs.push_back(mk(OP_STORE,  3'b010, 2'b00, 0, 0,     NEVER, 8, 0, 0, 4'b1111, 1, 1, 2'd3));
        vecs.push_back(mk(OP_NONE,   3'b000, 2'b00, 0, 0,     0,     3, 0, 0, 4'b0000, 0, 1, 2'd1));
        vecs.push_back(mk(OP_SYSTEM, 3'b000, 2'b00, 0, 0,     0,     3, 0, 0, 4'b0000, 0, 1, 2'd0));
        vecs.push_back(mk(OP_ALU,    3'b000, 2'b00, 0, NEVER, 0,     5, 0, 0, 4'b0000, 0, 1, 2'd3));

        // Reset state
        #1;
        check("reset strobes", {imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we}, 0);
        check("reset halt", halt, 0);
        check("reset trap_cause", trap_cause, 0);
        check("reset instret", instret, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) run_one(i, vecs[i]);

        // Counter wrap: a run of fences takes instret through 15 -> 0
        for (int i = 0; i < 18; i++) begin
            run_one(100 + i, mk(OP_FENCE, 3'b000, 2'b00, 0, 0, 0, 3, 0, 0, 4'b0000, 0, 0, 2'd0));
        end

        // Reset asserted between clock edges while a store waits in MEM
        set_op(OP_STORE);
        funct3 = 3'b010; addr_lo = 2'b00;
        begin
            bit seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                imem_ack = imem_req;
                #1;
                if (dmem_req) seen = 1;
            end
            imem_ack = 1'b0;
            check("midmem reached MEM", seen, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("midmem dmem_req", dmem_req, 0);
        check("midmem dmem_we", dmem_we, 0);
        check("midmem imem_req", imem_req, 0);
        check("midmem instret", instret, 0);
        check("midmem halt", halt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("release imem_req", imem_req, 1);
        check("release dmem_req", dmem_req, 0);
        check("release instret", instret, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
